// File: rtl/lut_sweep_pkg.sv
// Shared types and sizing helpers for the LUT bank sweeper.
package lut_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Number of truth-table rows for n inputs.
   function automatic int rows_of(input int n);
      return 1 << n;
   endfunction

   // Width of a function index; never narrower than one bit.
   function automatic int func_w_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam state_t RST_STATE = IDLE;
   localparam logic   RST_FLAG  = 1'b0;

endpackage

// File: rtl/lut_column.sv
// One function of the bank: a loadable truth table with two independent read ports.
module lut_column
   import lut_sweep_pkg::*;
#(
   parameter  int NUM_IN = 4,
   localparam int ROWS   = rows_of(NUM_IN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ROWS-1:0]   wdata,
   input  logic [NUM_IN-1:0] eval_row,
   input  logic [NUM_IN-1:0] sweep_row,
   output logic              eval_bit,
   output logic              sweep_bit
);

   logic [ROWS-1:0] tbl;

   // Truth table storage; cleared on reset, overwritten whole on a write.
   always_ff @(posedge clk) begin
      if (rst)     tbl <= '0;
      else if (we) tbl <= wdata;
   end

   assign eval_bit  = tbl[eval_row];
   assign sweep_bit = tbl[sweep_row];

endmodule

// File: rtl/lut_bank_sweeper.sv
// Bank of loadable truth tables with a registered live-eval path and a streaming row sweep.
module lut_bank_sweeper
   import lut_sweep_pkg::*;
#(
   parameter  int NUM_IN   = 4,
   parameter  int NUM_FUNC = 10,
   localparam int ROWS     = rows_of(NUM_IN),
   localparam int FUNC_W   = func_w_of(NUM_FUNC)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [FUNC_W-1:0]   cfg_func,
   input  logic [ROWS-1:0]     cfg_table,
   output logic                cfg_err,
   input  logic [NUM_IN-1:0]   in_vec,
   output logic [NUM_FUNC-1:0] eval_f,
   input  logic                start,
   output logic                busy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NUM_IN-1:0]   out_row,
   output logic [NUM_FUNC-1:0] out_f,
   output logic                out_last,
   output logic                done
);

   localparam logic [NUM_IN-1:0] LAST_ROW = '1;

   state_t              state, state_nx;
   logic [NUM_IN-1:0]   row, row_nx;
   logic                vld_nx;
   logic                cfg_acc;
   logic [NUM_FUNC-1:0] eval_raw, sweep_raw;

   // Tables are only writable while idle, so a sweep always sees one consistent bank.
   assign cfg_ready = (state == IDLE);
   assign cfg_acc   = cfg_valid & cfg_ready;

   // An out-of-range index matches no column, so the write simply falls on the floor.
   for (genvar k = 0; k < NUM_FUNC; k++) begin : g_col
      lut_column #(.NUM_IN(NUM_IN)) u_col (
         .clk       (clk),
         .rst       (rst),
         .we        (cfg_acc && (int'(cfg_func) == k)),
         .wdata     (cfg_table),
         .eval_row  (in_vec),
         .sweep_row (row),
         .eval_bit  (eval_raw[k]),
         .sweep_bit (sweep_raw[k])
      );
   end

   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign out_row  = row;
   assign out_last = out_valid && (row == LAST_ROW);
   assign out_f    = out_valid ? sweep_raw : '0;

   // Next state, row and beat-valid; the row only advances on an accepted beat.
   always_comb begin
      state_nx = state;
      row_nx   = row;
      vld_nx   = out_valid;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = SWEEP;
               row_nx   = '0;
               vld_nx   = 1'b1;
            end
         end
         SWEEP: begin
            if (out_ready) begin
               if (row == LAST_ROW) begin
                  state_nx = DONE;
                  row_nx   = '0;
                  vld_nx   = 1'b0;
               end else begin
                  row_nx = row + 1'b1;
               end
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Sweep control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RST_STATE;
         row       <= '0;
         out_valid <= RST_FLAG;
      end else begin
         state     <= state_nx;
         row       <= row_nx;
         out_valid <= vld_nx;
      end
   end

   // Registered live evaluation and the config error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         eval_f  <= '0;
         cfg_err <= RST_FLAG;
      end else begin
         eval_f  <= eval_raw;
         cfg_err <= cfg_acc && (int'(cfg_func) >= NUM_FUNC);
      end
   end

endmodule
